ecc_correct_ctrl: RTL and testbench

//  Sequences one 32-bit ECC read correction through the syndrome decoders.
//  - Accepts a raw data word with its two syndromes.
//  - Drives the syndromes to the single- and double-error location decoders.
//  - Classifies the error and XOR-corrects the word.
//  - Returns the result on a valid/ready port.
//  - Optionally issues a scrub write-back of corrected words.

---
 rtl/ecc_correct_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_ecc_correct_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_correct_ctrl.sv
// ----------------------------------------------------------------------------
// ecc_correct_ctrl
//   Sequences one 32-bit ECC read correction at a time. A raw word and its two
//   syndromes are captured, the syndromes are presented to the external
//   single- and double-error location decoders, and the error is classified
//   once the decoders have had DEC_LAT cycles to settle. The word is then
//   XOR-corrected and returned on a valid/ready port. Single- and
//   double-corrected words can also be scrubbed back to memory through a
//   req/ack write-back port.
//
// Parameters
//   DEC_LAT   decoder latency in cycles (0..3)
//   CNT_W     width of the saturating error statistics counters
//   SCRUB_EN  1: write back corrected words, 0: never request a write-back
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        raw word handshake
//   in_data, in_synd_a/b     raw word and syndromes
//   dec_synd_a/b             captured syndromes driven to the decoders
//   sgl_loc, dbl_loc         decoder location masks (sampled in classify cycle)
//   out_valid/out_ready      result handshake
//   out_data, out_err        corrected word and class (00/01/10/11)
//   wb_req/wb_ack, wb_data   scrub write-back handshake and data
//   cnt_clr                  synchronous clear of both counters
//   cnt_corr, cnt_uncorr     saturating corrected / uncorrectable counts
// ----------------------------------------------------------------------------
module ecc_correct_ctrl #(
  parameter int DEC_LAT  = 1,
  parameter int CNT_W    = 16,
  parameter bit SCRUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [6:0]       in_synd_a,
  input  logic [7:0]       in_synd_b,
  output logic [6:0]       dec_synd_a,
  output logic [7:0]       dec_synd_b,
  input  logic [31:0]      sgl_loc,
  input  logic [31:0]      dbl_loc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_err,
  output logic             wb_req,
  input  logic             wb_ack,
  output logic [31:0]      wb_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_OUTPUT = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [1:0]       LAT      = 2'(DEC_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic             in_ready_q, in_ready_d;
  logic [31:0]      data_q;
  logic [6:0]       synd_a_q;
  logic [7:0]       synd_b_q;
  logic [31:0]      out_data_q, out_data_d;
  logic [1:0]       out_err_q, out_err_d;
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic             capture;
  logic             classify;
  logic             out_hs;
  logic [1:0]       err_c;
  logic [31:0]      mask_c;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [31:0] x);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

  // Exactly two bits set: clearing the lowest set bit leaves a one-hot value.
  function automatic logic is_twohot(input logic [31:0] x);
    return is_onehot(x & (x - 32'd1));
  endfunction

  // Error classification, highest priority first.
  always_comb begin
    err_c  = 2'b11;
    mask_c = 32'd0;
    if ((synd_a_q == 7'd0) && (synd_b_q == 8'd0)) begin
      err_c  = 2'b00;
      mask_c = 32'd0;
    end else if (is_onehot(sgl_loc)) begin
      err_c  = 2'b01;
      mask_c = sgl_loc;
    end else if (is_twohot(dbl_loc)) begin
      err_c  = 2'b10;
      mask_c = dbl_loc;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    capture  = 1'b0;
    classify = 1'b0;
    out_hs   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          capture = 1'b1;
          wait_d  = LAT;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (wait_q == 2'd0) begin
          classify = 1'b1;
          state_d  = S_OUTPUT;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_hs = 1'b1;
          if (SCRUB_EN && ((out_err_q == 2'b01) || (out_err_q == 2'b10))) begin
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WB: begin
        if (wb_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is registered so it stays low while reset is asserted and rises
  // on the first edge after release.
  assign in_ready_d = (state_d == S_IDLE);

  always_comb begin
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (classify) begin
      out_data_d = data_q ^ mask_c;
      out_err_d  = err_c;
    end
  end

  // Counters: clear beats increment; increments stop at all-ones.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_hs) begin
      if (((out_err_q == 2'b01) || (out_err_q == 2'b10)) && (cnt_corr_q != CNT_MAX)) begin
        cnt_corr_d = cnt_corr_q + CNT_ONE;
      end
      if ((out_err_q == 2'b11) && (cnt_uncorr_q != CNT_MAX)) begin
        cnt_uncorr_d = cnt_uncorr_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= 2'd0;
      in_ready_q   <= 1'b0;
      data_q       <= 32'd0;
      synd_a_q     <= 7'd0;
      synd_b_q     <= 8'd0;
      out_data_q   <= 32'd0;
      out_err_q    <= 2'b00;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
      if (capture) begin
        data_q   <= in_data;
        synd_a_q <= in_synd_a;
        synd_b_q <= in_synd_b;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign dec_synd_a = synd_a_q;
  assign dec_synd_b = synd_b_q;
  assign out_valid  = (state_q == S_OUTPUT);
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign wb_req     = (state_q == S_WB);
  assign wb_data    = out_data_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_ecc_correct_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ecc_correct_ctrl
//   Three controller instances share stimulus: u_a (defaults), u_b (DEC_LAT 3,
//   CNT_W 2, no scrub) and u_c (DEC_LAT 0). 'sel' picks which instance gets
//   in_valid and whose outputs are observed. Expected results are pushed into
//   a queue when a word is driven and popped when out_valid is seen.
// ----------------------------------------------------------------------------
module tb_ecc_correct_ctrl;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic [6:0]  in_synd_a = 7'd0;
  logic [7:0]  in_synd_b = 8'd0;
  logic [31:0] sgl_loc = 32'd0;
  logic [31:0] dbl_loc = 32'd0;
  logic        out_ready = 1'b0;
  logic        wb_ack = 1'b0;
  logic        cnt_clr = 1'b0;
  int          sel = 0;

  logic [2:0]  iv;
  logic [2:0]  in_ready_v, out_valid_v, wb_req_v;
  logic [6:0]  dsa_v [3];
  logic [7:0]  dsb_v [3];
  logic [31:0] od_v [3];
  logic [1:0]  oe_v [3];
  logic [31:0] wd_v [3];
  logic [15:0] cc_v [3];
  logic [15:0] cu_v [3];
  logic [1:0]  cc_b, cu_b;

  logic        m_in_ready, m_out_valid, m_wb_req;
  logic [6:0]  m_dsa;
  logic [31:0] m_od, m_wd;
  logic [1:0]  m_oe;
  logic [15:0] m_cc, m_cu;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign iv[0] = in_valid && (sel == 0);
  assign iv[1] = in_valid && (sel == 1);
  assign iv[2] = in_valid && (sel == 2);
  assign cc_v[1] = {14'd0, cc_b};
  assign cu_v[1] = {14'd0, cu_b};

  always_comb begin
    m_in_ready  = in_ready_v[sel];
    m_out_valid = out_valid_v[sel];
    m_wb_req    = wb_req_v[sel];
    m_dsa       = dsa_v[sel];
    m_od        = od_v[sel];
    m_oe        = oe_v[sel];
    m_wd        = wd_v[sel];
    m_cc        = cc_v[sel];
    m_cu        = cu_v[sel];
  end

  ecc_correct_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_synd_a(in_synd_a), .in_synd_b(in_synd_b),
    .dec_synd_a(dsa_v[0]), .dec_synd_b(dsb_v[0]), .sgl_loc(sgl_loc), .dbl_loc(dbl_loc),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(od_v[0]), .out_err(oe_v[0]),
    .wb_req(wb_req_v[0]), .wb_ack(wb_ack), .wb_data(wd_v[0]), .cnt_clr(cnt_clr),
    .cnt_corr(cc_v[0]), .cnt_uncorr(cu_v[0])
  );

  ecc_correct_ctrl #(.DEC_LAT(3), .CNT_W(2), .SCRUB_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_synd_a(in_synd_a), .in_synd_b(in_synd_b),
    .dec_synd_a(dsa_v[1]), .dec_synd_b(dsb_v[1]), .sgl_loc(sgl_loc), .dbl_loc(dbl_loc),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(od_v[1]), .out_err(oe_v[1]),
    .wb_req(wb_req_v[1]), .wb_ack(wb_ack), .wb_data(wd_v[1]), .cnt_clr(cnt_clr),
    .cnt_corr(cc_b), .cnt_uncorr(cu_b)
  );

  ecc_correct_ctrl #(.DEC_LAT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_synd_a(in_synd_a), .in_synd_b(in_synd_b),
    .dec_synd_a(dsa_v[2]), .dec_synd_b(dsb_v[2]), .sgl_loc(sgl_loc), .dbl_loc(dbl_loc),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(od_v[2]), .out_err(oe_v[2]),
    .wb_req(wb_req_v[2]), .wb_ack(wb_ack), .wb_data(wd_v[2]), .cnt_clr(cnt_clr),
    .cnt_corr(cc_v[2]), .cnt_uncorr(cu_v[2])
  );

  // Independent reference classification used for the mixed-traffic test.
  function automatic exp_t model(input logic [31:0] d, input logic [6:0] a,
                                 input logic [7:0] b, input logic [31:0] s,
                                 input logic [31:0] db);
    exp_t r;
    if (a == 7'd0 && b == 8'd0)   begin r.d = d;      r.e = 2'b00; end
    else if ($countones(s) == 1)  begin r.d = d ^ s;  r.e = 2'b01; end
    else if ($countones(db) == 2) begin r.d = d ^ db; r.e = 2'b10; end
    else                          begin r.d = d;      r.e = 2'b11; end
    return r;
  endfunction

  // Offer one word and push its expected result; returns just after capture edge.
  task automatic drive_word(input logic [31:0] d, input logic [6:0] a, input logic [7:0] b,
                            input logic [31:0] s, input logic [31:0] db,
                            input logic [31:0] ed, input logic [1:0] ee);
    int n = 0;
    exp_t x;
    x.d = ed; x.e = ee;
    sb_q.push_back(x);
    in_data = d; in_synd_a = a; in_synd_b = b; sgl_loc = s; dbl_loc = db;
    in_valid = 1'b1;
    while (!m_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", m_in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!m_out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (m_in_ready !== 1'b0 || m_out_valid !== 1'b0 || m_wb_req !== 1'b0 ||
        m_od !== 32'd0 || m_oe !== 2'd0 || m_dsa !== 7'd0 || m_cc !== 16'd0 || m_cu !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%0b ov=%0b wb=%0b od=%h oe=%0d dsa=%0d cc=%0d cu=%0d required all 0",
               m_in_ready, m_out_valid, m_wb_req, m_od, m_oe, m_dsa, m_cc, m_cu);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (m_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_early: in_ready=%0b required 0", m_in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise: in_ready=%0b required 1", m_in_ready);
    end
  endtask

  task automatic test_clean();
    int cyc;
    exp_t x;
    sel = 0;
    drive_word(32'hDEADBEEF, 7'd0, 8'd0, 32'h1, 32'h3, 32'hDEADBEEF, 2'b00);
    wait_out(cyc);
    n_cmp++;
    if (cyc !== 2) begin n_fail++; $display("FAIL clean_latency: cycles=%0d required 2", cyc); end
    x = sb_q.pop_front();
    n_cmp++;
    if (m_od !== x.d || m_oe !== x.e) begin
      n_fail++; $display("FAIL clean_result: data=%h err=%0d required data=%h err=%0d", m_od, m_oe, x.d, x.e);
    end
    handshake();
    n_cmp++;
    if (m_wb_req !== 1'b0 || m_out_valid !== 1'b0 || m_cc !== 16'd0 || m_cu !== 16'd0) begin
      n_fail++; $display("FAIL clean_after: wb=%0b ov=%0b cc=%0d cu=%0d required 0 0 0 0", m_wb_req, m_out_valid, m_cc, m_cu);
    end
  endtask

  task automatic test_double();
    int cyc;
    exp_t x;
    sel = 0;
    drive_word(32'h00000003, 7'd48, 8'd201, 32'h0, 32'h3, 32'h0, 2'b10);
    n_cmp++;
    if (m_dsa !== 7'd48 || dsb_v[0] !== 8'd201) begin
      n_fail++; $display("FAIL double_dec_synd: a=%0d b=%0d required 48 201", m_dsa, dsb_v[0]);
    end
    wait_out(cyc);
    x = sb_q.pop_front();
    n_cmp++;
    if (m_od !== x.d || m_oe !== x.e) begin
      n_fail++; $display("FAIL double_result: data=%h err=%0d required data=%h err=%0d", m_od, m_oe, x.d, x.e);
    end
    handshake();
    repeat (2) begin
      n_cmp++;
      if (m_wb_req !== 1'b1 || m_wd !== 32'h0) begin
        n_fail++; $display("FAIL double_wb_hold: wb_req=%0b wb_data=%h required 1 00000000", m_wb_req, m_wd);
      end
      @(posedge clk); #1;
    end
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    n_cmp++;
    if (m_wb_req !== 1'b0 || m_cc !== 16'd1) begin
      n_fail++; $display("FAIL double_wb_done: wb_req=%0b cnt_corr=%0d required 0 1", m_wb_req, m_cc);
    end
  endtask

  task automatic test_single_stall();
    int cyc;
    exp_t x;
    sel = 0;
    drive_word(32'h80000001, 7'd5, 8'd9, 32'h80000000, 32'h0, 32'h00000001, 2'b01);
    wait_out(cyc);
    x = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (m_out_valid !== 1'b1 || m_od !== x.d || m_oe !== x.e) begin
        n_fail++; $display("FAIL single_stall_%0d: ov=%0b data=%h err=%0d required 1 %h %0d", i, m_out_valid, m_od, m_oe, x.d, x.e);
      end
      @(posedge clk); #1;
    end
    handshake();
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    n_cmp++;
    if (m_cc !== 16'd2 || m_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_after: cnt_corr=%0d in_ready=%0b required 2 1", m_cc, m_in_ready);
    end
  endtask

  task automatic test_uncorrectable();
    int cyc;
    exp_t x;
    sel = 0;
    wb_ack = 1'b1;
    drive_word(32'h12345678, 7'd3, 8'd7, 32'h0, 32'h7, 32'h12345678, 2'b11);
    wait_out(cyc);
    x = sb_q.pop_front();
    n_cmp++;
    if (m_od !== x.d || m_oe !== x.e) begin
      n_fail++; $display("FAIL uncorr_result: data=%h err=%0d required data=%h err=%0d", m_od, m_oe, x.d, x.e);
    end
    handshake();
    wb_ack = 1'b0;
    n_cmp++;
    if (m_wb_req !== 1'b0 || m_cu !== 16'd1 || m_cc !== 16'd2 || m_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL uncorr_after: wb=%0b cu=%0d cc=%0d rdy=%0b required 0 1 2 1", m_wb_req, m_cu, m_cc, m_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4] = '{32'hA5A5A5A5, 32'h0000F000, 32'h11111111, 32'hFFFFFFFF};
    logic [6:0]  a [4] = '{7'd1, 7'd0, 7'd9, 7'd2};
    logic [31:0] s [4] = '{32'h00000010, 32'h00000004, 32'h00000003, 32'h00000000};
    logic [31:0] db[4] = '{32'h00000003, 32'h00000000, 32'h00000101, 32'h80000001};
    int cyc;
    exp_t m, x;
    sel = 0;
    wb_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m = model(d[i], a[i], 8'd0, s[i], db[i]);
      drive_word(d[i], a[i], 8'd0, s[i], db[i], m.d, m.e);
      wait_out(cyc);
      x = sb_q.pop_front();
      n_cmp++;
      if (m_od !== x.d || m_oe !== x.e) begin
        n_fail++; $display("FAIL b2b_%0d: data=%h err=%0d required data=%h err=%0d", i, m_od, m_oe, x.d, x.e);
      end
      handshake();
    end
    @(posedge clk); #1;
    wb_ack = 1'b0;
    // Corrected: word0 (single), word2 (double), word3 (double); word1 clean.
    n_cmp++;
    if (m_cc !== 16'd5 || m_cu !== 16'd1) begin
      n_fail++; $display("FAIL b2b_counts: cc=%0d cu=%0d required 5 1", m_cc, m_cu);
    end
  endtask

  task automatic test_latency_sat();
    int cyc;
    exp_t x;
    sel = 2;
    drive_word(32'h0BADF00D, 7'd0, 8'd0, 32'h0, 32'h0, 32'h0BADF00D, 2'b00);
    wait_out(cyc);
    x = sb_q.pop_front();
    n_cmp++;
    if (cyc !== 1 || m_od !== x.d) begin
      n_fail++; $display("FAIL lat0: cycles=%0d data=%h required 1 %h", cyc, m_od, x.d);
    end
    handshake();
    sel = 1;
    for (int i = 1; i <= 4; i++) begin
      drive_word(32'hCAFE0000 + i, 7'd1, 8'd0, 32'h0, 32'h0, 32'hCAFE0000 + i, 2'b11);
      wait_out(cyc);
      x = sb_q.pop_front();
      n_cmp++;
      if (cyc !== 4 || m_od !== x.d || m_oe !== x.e) begin
        n_fail++; $display("FAIL lat3_%0d: cycles=%0d data=%h err=%0d required 4 %h %0d", i, cyc, m_od, m_oe, x.d, x.e);
      end
      handshake();
      n_cmp++;
      if (m_cu !== ((i > 3) ? 16'd3 : 16'(i))) begin
        n_fail++; $display("FAIL sat_%0d: cnt_uncorr=%0d required %0d", i, m_cu, (i > 3) ? 3 : i);
      end
    end
    drive_word(32'h00000010, 7'd1, 8'd1, 32'h00000010, 32'h0, 32'h0, 2'b01);
    wait_out(cyc);
    x = sb_q.pop_front();
    handshake();
    n_cmp++;
    if (m_wb_req !== 1'b0 || m_cc !== 16'd1 || m_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL noscrub: wb=%0b cc=%0d rdy=%0b required 0 1 1", m_wb_req, m_cc, m_in_ready);
    end
    drive_word(32'h0000FFFF, 7'd2, 8'd0, 32'h0, 32'h0, 32'h0000FFFF, 2'b11);
    wait_out(cyc);
    x = sb_q.pop_front();
    cnt_clr = 1'b1;
    handshake();
    cnt_clr = 1'b0;
    n_cmp++;
    if (m_cu !== 16'd0 || m_cc !== 16'd0) begin
      n_fail++; $display("FAIL clr_wins: cu=%0d cc=%0d required 0 0", m_cu, m_cc);
    end
  endtask

  task automatic test_reset_mid_wb();
    int cyc;
    exp_t x;
    sel = 0;
    drive_word(32'h00000100, 7'd4, 8'd4, 32'h00000100, 32'h0, 32'h0, 2'b01);
    wait_out(cyc);
    x = sb_q.pop_front();
    handshake();
    n_cmp++;
    if (m_wb_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_wb_req: wb_req=%0b required 1", m_wb_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_wb_req !== 1'b0 || m_out_valid !== 1'b0 || m_cc !== 16'd0 || m_cu !== 16'd0 || m_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_wb_reset: wb=%0b ov=%0b cc=%0d cu=%0d rdy=%0b required 0 0 0 0 0",
                         m_wb_req, m_out_valid, m_cc, m_cu, m_in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (m_in_ready !== 1'b1 || m_wb_req !== 1'b0 || m_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_wb_release: rdy=%0b wb=%0b ov=%0b required 1 0 0", m_in_ready, m_wb_req, m_out_valid);
    end
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_left: entries=%0d required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_double();
    test_single_stall();
    test_uncorrectable();
    test_back_to_back();
    test_latency_sat();
    test_reset_mid_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
